// File: rtl/corelet_acc_stage.sv
// corelet_acc_stage: accumulates psum vectors over several input-channel passes into a pixel bank, then drains activated vectors.
// Define CORELET_ACC_RELU_EN to apply ReLU on the output path; otherwise the saturated value passes unchanged.
module corelet_acc_stage #(
  parameter int col       = 8,
  parameter int psum_bw   = 16,
  parameter int acc_depth = 16,
  parameter int pass_bw   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(acc_depth):0] cfg_npix,
  input  logic [pass_bw-1:0]         cfg_npass,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [psum_bw*col-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [psum_bw*col-1:0]     out_data,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(acc_depth);
  localparam int CW = AW + 1;
  localparam int DW = psum_bw * col;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      pix_q, pix_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [pass_bw-1:0] pass_q, pass_d;
  logic [pass_bw-1:0] npass_q, npass_d;
  logic [CW-1:0]      npix_q, npix_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic               done_q, done_d;

  logic [DW-1:0]      bank_mem [acc_depth];

  logic [DW-1:0]      bank_rd;
  logic [DW-1:0]      sum_vec;
  logic [DW-1:0]      wr_vec;
  logic [DW-1:0]      act_src;
  logic [DW-1:0]      act_vec;
  logic [AW-1:0]      rd_nxt;
  logic               pix_last;
  logic               pass_last;
  logic               rd_last;
  logic               cfg_ok;

  assign bank_rd   = bank_mem[pix_q];
  assign wr_vec    = (pass_q == '0) ? in_data : sum_vec;
  assign rd_nxt    = rd_ptr_q + AW'(1);
  assign pix_last  = ({1'b0, pix_q} == (npix_q - CW'(1)));
  assign pass_last = (pass_q == (npass_q - pass_bw'(1)));
  assign rd_last   = ({1'b0, rd_ptr_q} == (npix_q - CW'(1)));
  assign cfg_ok    = (cfg_npix != '0) && (cfg_npix <= CW'(acc_depth)) && (cfg_npass != '0);

  // The first drained word must reflect the beat being written right now when npix == 1.
  always_comb begin
    act_src = bank_mem[rd_nxt];
    if (state_q == S_ACC) begin
      act_src = (pix_q == '0) ? wr_vec : bank_mem[0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_lane
      logic [psum_bw-1:0] a_lane;
      logic [psum_bw-1:0] b_lane;
      logic [psum_bw:0]   sum_w;
      logic [psum_bw-1:0] src_lane;

      assign a_lane = bank_rd[gi*psum_bw +: psum_bw];
      assign b_lane = in_data[gi*psum_bw +: psum_bw];
      assign sum_w  = {a_lane[psum_bw-1], a_lane} + {b_lane[psum_bw-1], b_lane};

      // Overflow iff the two top bits of the widened sum disagree; clamp toward the sign of the sum.
      assign sum_vec[gi*psum_bw +: psum_bw] =
        (sum_w[psum_bw] == sum_w[psum_bw-1]) ? sum_w[psum_bw-1:0] :
        (sum_w[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}});

      assign src_lane = act_src[gi*psum_bw +: psum_bw];
`ifdef CORELET_ACC_RELU_EN
      assign act_vec[gi*psum_bw +: psum_bw] = src_lane[psum_bw-1] ? '0 : src_lane;
`else
      assign act_vec[gi*psum_bw +: psum_bw] = src_lane;
`endif
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    rd_ptr_d   = rd_ptr_q;
    pass_d     = pass_q;
    npass_d    = npass_q;
    npix_d     = npix_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) begin
          npix_d   = cfg_npix;
          npass_d  = cfg_npass;
          pix_d    = '0;
          pass_d   = '0;
          rd_ptr_d = '0;
          state_d  = S_ACC;
        end
      end

      S_ACC: begin
        if (in_valid) begin
          if (pix_last) begin
            pix_d = '0;
            if (pass_last) begin
              state_d    = S_DRAIN;
              rd_ptr_d   = '0;
              out_data_d = act_vec;
            end else begin
              pass_d = pass_q + pass_bw'(1);
            end
          end else begin
            pix_d = pix_q + AW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (out_ready) begin
          if (rd_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            rd_ptr_d   = rd_nxt;
            out_data_d = act_vec;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pix_q      <= '0;
      rd_ptr_q   <= '0;
      pass_q     <= '0;
      npass_q    <= '0;
      npix_q     <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      rd_ptr_q   <= rd_ptr_d;
      pass_q     <= pass_d;
      npass_q    <= npass_d;
      npix_q     <= npix_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
    end
  end

  // Bank contents carry no reset; pass 0 overwrites every pixel before it is ever read.
  always_ff @(posedge clk) begin
    if (state_q == S_ACC && in_valid) begin
      bank_mem[pix_q] <= wr_vec;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/corelet_acc_stage.md
Name: corelet_acc_stage

Overview:
- Parametrised output stage for the corelet.
- Accepts per-column psum vectors from the OFIFO drain path and accumulates them across multiple input-channel passes into an internal pixel bank, with signed saturation.
- Once all passes are in, streams one activated vector per pixel to the downstream SRAM writer over a valid/ready interface.
- Replaces the single-register, externally-controlled SFP with a self-sequenced, multi-pixel, back-pressurable stage.

Parameters:
- col, 8, number of output columns (lanes).
- psum_bw, 16, signed width of each lane, both input and output.
- acc_depth, 16, number of pixel entries in the accumulation bank; power of two, at least 2.
- pass_bw, 8, width of the pass-count configuration.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; latches cfg_* and begins a job.
- cfg_npix  input  $clog2(acc_depth)+1  pixels per pass; valid range 1..acc_depth.
- cfg_npass  input  pass_bw  passes per job; valid range 1..2^pass_bw-1.
- in_valid  input  1  in_data valid.
- in_ready  output  1  stage accepts in_data.
- in_data  input  psum_bw*col  psum vector; lane i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  psum_bw*col  activated result vector.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse after the last output beat.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, pixel and pass counters 0; in_ready, out_valid, busy, done all 0; out_data 0. Bank contents are not reset and are don't-care.
- FSM states and transitions:
  - IDLE: on start, latch cfg_npix and cfg_npass, clear counters, go to ACC.
  - start is ignored if cfg_npix == 0, cfg_npix > acc_depth, or cfg_npass == 0; the FSM stays in IDLE and done is not asserted.
  - start is ignored in any state other than IDLE.
  - ACC: in_ready = 1. Each beat (in_valid && in_ready) writes pixel p of pass k:
    - k == 0: bank[p] <= in_data (overwrite; no stale data carried in).
    - k > 0: per lane, bank[p] <= sat(bank[p] + in_data).
    - p increments each beat; when p == npix-1 it wraps to 0 and k increments.
    - The beat with p == npix-1 and k == npass-1 moves the FSM to DRAIN next cycle, with the read pointer at 0.
  - DRAIN: in_ready = 0, out_valid = 1, out_data = act(bank[rd_ptr]).
    - out_data is sourced from registers; there is no combinational path from out_ready to out_data.
    - On out_valid && out_ready, rd_ptr increments.
    - On the beat with rd_ptr == npix-1: done = 1 in the following cycle, state returns to IDLE, and out_valid drops in that same cycle.
    - While out_ready == 0, out_valid stays 1 and out_data stays stable.
- Saturation: per lane, compute the sum at psum_bw+1 bits, then clamp to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- Activation: act() per lane is ReLU (negative -> 0) or identity; see Optional Feature.
- Latency: last input beat at cycle t -> out_valid = 1 at t+1.
- in_valid in IDLE or DRAIN is not consumed.
- Reset mid-job: any state returns to IDLE next cycle; the partial job is discarded.
- busy = (state != IDLE); busy deasserts in the same cycle done pulses.

Optional Feature:
- Macro: CORELET_ACC_RELU_EN.
- Defined: act() = ReLU per lane.
- Undefined: act() = identity; the saturated signed value is output unchanged.
- Accumulation and saturation are identical in both builds.

Test Plan (col=8, psum_bw=16, acc_depth=16, relu build unless noted):
1. start npix=2 npass=1; beats: all lanes 5, then all lanes -3 -> output beat0 all lanes 5, beat1 all lanes 0; done pulses 1 cycle after beat1; busy then 0.
2. npix=1 npass=3; beats 100, 200, -50 on every lane -> single output 250 per lane; out_valid rises 1 cycle after the third input beat.
3. npix=1 npass=2, lane0: 30000 + 30000, lane1: -30000 + -30000:
   - relu build -> lane0 32767, lane1 0.
   - non-relu build -> lane0 32767, lane1 -32768.
4. npix=4 npass=1 with out_ready held low 3 cycles during beat 2 -> out_valid stays 1, out_data stable, pixel 2 emitted exactly once, 4 beats total in order 0..3.
5. npix=4 npass=2, reset asserted after 3 input beats -> next cycle busy=0, in_ready=0, out_valid=0. A fresh job npix=1 npass=1 with value 7 then outputs 7; no stale sum from the aborted job.
6. start with npass=0 -> stays IDLE, no done. Second start pulse during ACC is ignored; job completes per the original cfg (npix=3 -> exactly 3 output beats).
